// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit adder among NUM_REQ requesters.
// Two-stage pipeline: operand register, then sum register driving the response outputs.
module adder_share_arbiter #(
    parameter int unsigned WIDTH    = 92,
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    output logic [ID_WIDTH-1:0]      rsp_id,
    output logic [WIDTH:0]           rsp_sum,
    input  logic                     rsp_ready
);

    logic [ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                s1_valid_q, s1_valid_d;
    logic [ID_WIDTH-1:0] s1_id_q, s1_id_d;
    logic [WIDTH-1:0]    s1_a_q, s1_a_d;
    logic [WIDTH-1:0]    s1_b_q, s1_b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
    logic [WIDTH:0]      rsp_sum_q, rsp_sum_d;

    logic                grant_found;
    logic [ID_WIDTH-1:0] grant_id;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] ptr_next;
    logic [WIDTH-1:0]    grant_a, grant_b;
    logic                s2_free, s1_free, s1_adv, req_xfer;

    assign s2_free = !rsp_valid_q || rsp_ready;
    assign s1_free = !s1_valid_q || s2_free;
    assign s1_adv  = s1_valid_q && s2_free;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ID_WIDTH'((32'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    assign ptr_next  = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
    assign grant_a   = req_a[32'(grant_id)*WIDTH +: WIDTH];
    assign grant_b   = req_b[32'(grant_id)*WIDTH +: WIDTH];
    assign req_xfer  = grant_found && s1_free && !rst;
    assign req_ready = req_xfer ? (NUM_REQ'(1) << grant_id) : '0;

    always_comb begin
        ptr_d       = ptr_q;
        s1_valid_d  = s1_valid_q;
        s1_id_d     = s1_id_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;

        if (req_xfer) begin
            ptr_d      = ptr_next;
            s1_valid_d = 1'b1;
            s1_id_d    = grant_id;
            s1_a_d     = grant_a;
            s1_b_d     = grant_b;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        // Sum payload only moves on advance, so it holds while stalled and after draining.
        if (s1_adv) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = s1_id_q;
            rsp_sum_d   = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: scenario tasks plus a negedge scoreboard and round-robin model.
module tb_adder_share_arbiter;

    localparam int unsigned WIDTH    = 92;
    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned ID_WIDTH = 2;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_a = '0;
    logic [NUM_REQ*WIDTH-1:0] req_b = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     rsp_valid;
    logic [ID_WIDTH-1:0]      rsp_id;
    logic [WIDTH:0]           rsp_sum;
    logic                     rsp_ready = 1'b1;

    always #5 clk = ~clk;

    adder_share_arbiter #(
        .WIDTH    (WIDTH),
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_ready (rsp_ready)
    );

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [WIDTH:0]      sum;
    } exp_t;

    exp_t                sb_q[$];
    int                  checks = 0;
    int                  errors = 0;
    int                  rsp_count = 0;
    logic                m_s1 = 1'b0;
    logic                m_rsp = 1'b0;
    logic [ID_WIDTH-1:0] m_ptr = '0;
    int                  wait_cnt[NUM_REQ];

    // Reference pipeline/arbiter model, evaluated mid-cycle with the inputs for the next edge.
    always @(negedge clk) begin : monitor
        logic [NUM_REQ-1:0]  exp_ready;
        logic                found;
        logic [ID_WIDTH-1:0] win;
        logic [ID_WIDTH-1:0] cand;
        logic                s2_free, s1_free, adv;
        logic [WIDTH:0]      s;
        exp_t                e;
        if (rst) begin
            checks++;
            if (req_ready !== '0) begin
                errors++;
                $display("FAIL reset_req_ready: got %b, required 0", req_ready);
            end
            sb_q.delete();
            m_s1  = 1'b0;
            m_rsp = 1'b0;
            m_ptr = '0;
            for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
        end else begin
            checks++;
            if (rsp_valid !== m_rsp) begin
                errors++;
                $display("FAIL model_rsp_valid: got %b, required %b", rsp_valid, m_rsp);
            end
            found = 1'b0;
            win   = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = ID_WIDTH'((int'(m_ptr) + k) % NUM_REQ);
                if (!found && req_valid[cand]) begin
                    found = 1'b1;
                    win   = cand;
                end
            end
            s2_free   = !m_rsp || rsp_ready;
            s1_free   = !m_s1 || s2_free;
            adv       = m_s1 && s2_free;
            exp_ready = (found && s1_free) ? (NUM_REQ'(1) << win) : '0;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL model_req_ready: got %b, required %b (valid %b ptr %0d)",
                         req_ready, exp_ready, req_valid, m_ptr);
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got response id %0d, required none", rsp_id);
                end else begin
                    e = sb_q.pop_front();
                    rsp_count++;
                    if (rsp_id !== e.id || rsp_sum !== e.sum) begin
                        errors++;
                        $display("FAIL sb_result: got id %0d sum %h, required id %0d sum %h",
                                 rsp_id, rsp_sum, e.id, e.sum);
                    end
                end
            end
            for (int i = 0; i < NUM_REQ; i++) if (!req_valid[i]) wait_cnt[i] = 0;
            if (exp_ready != '0) begin
                s = {1'b0, req_a[int'(win)*WIDTH +: WIDTH]} + {1'b0, req_b[int'(win)*WIDTH +: WIDTH]};
                e.id  = win;
                e.sum = s;
                sb_q.push_back(e);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (i == int'(win)) begin
                        wait_cnt[i] = 0;
                    end else if (req_valid[i]) begin
                        wait_cnt[i]++;
                        checks++;
                        if (wait_cnt[i] > int'(NUM_REQ) - 1) begin
                            errors++;
                            $display("FAIL fairness: requester %0d waited %0d transfers, max %0d",
                                     i, wait_cnt[i], NUM_REQ - 1);
                        end
                    end
                end
                m_ptr = (win == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win + ID_WIDTH'(1);
            end
            m_rsp = adv ? 1'b1 : (rsp_ready ? 1'b0 : m_rsp);
            m_s1  = (exp_ready != '0) ? 1'b1 : (adv ? 1'b0 : m_s1);
        end
    end

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'({$urandom, $urandom, $urandom});
    endfunction

    task automatic set_lane(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_sum !== '0 || req_ready !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got valid %b id %0d sum %h ready %b, required all 0",
                         rsp_valid, rsp_id, rsp_sum, req_ready);
            end
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b, required 0001", req_ready);
        end
        idle();
    endtask

    task automatic test_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH:0] exp_sum);
        int n;
        rsp_ready = 1'b1;
        set_lane(2, a, b);
        req_valid = 4'b0100;
        n = 0;
        @(negedge clk);
        while (req_ready[2] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready[2] !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got ready %b, required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got rsp_valid %b, required 0", rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_sum !== exp_sum) begin
            errors++;
            $display("FAIL single_result: got valid %b id %0d sum %h, required 1 2 %h",
                     rsp_valid, rsp_id, rsp_sum, exp_sum);
        end
        idle();
    endtask

    task automatic test_round_robin();
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < NUM_REQ; i++) set_lane(i, rnd(), rnd());
            @(negedge clk);
            checks++;
            if (req_ready !== (NUM_REQ'(1) << (c % NUM_REQ))) begin
                errors++;
                $display("FAIL rr_grant: cycle %0d got %b, required id %0d", c, req_ready,
                         c % NUM_REQ);
            end
            if (c >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_WIDTH'((c - 2) % NUM_REQ)) begin
                    errors++;
                    $display("FAIL rr_rsp: cycle %0d got valid %b id %0d, required 1 %0d",
                             c, rsp_valid, rsp_id, (c - 2) % NUM_REQ);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_backpressure();
        int                  xfers;
        int                  rsps;
        logic [ID_WIDTH-1:0] hold_id;
        logic [WIDTH:0]      hold_sum;
        xfers     = 0;
        rsps      = 0;
        hold_id   = '0;
        hold_sum  = '0;
        rsp_ready = 1'b0;
        set_lane(0, rnd(), rnd());
        set_lane(1, rnd(), rnd());
        req_valid = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            xfers += $countones(req_valid & req_ready);
            if (c == 2) begin
                hold_id  = rsp_id;
                hold_sum = rsp_sum;
            end else if (c > 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_sum !== hold_sum) begin
                    errors++;
                    $display("FAIL bp_hold: got valid %b id %0d sum %h, required 1 %0d %h",
                             rsp_valid, rsp_id, rsp_sum, hold_id, hold_sum);
                end
            end
            if (c < 4) tick();
        end
        checks++;
        if (xfers != 2 || req_ready !== '0) begin
            errors++;
            $display("FAIL bp_xfers: got %0d transfers ready %b, required 2 and 0", xfers,
                     req_ready);
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (rsp_id !== hold_id || rsp_sum !== hold_sum) begin
                    errors++;
                    $display("FAIL bp_first: got id %0d sum %h, required %0d %h", rsp_id,
                             rsp_sum, hold_id, hold_sum);
                end
            end
            if (rsp_valid === 1'b1) rsps++;
            tick();
        end
        checks++;
        if (rsps != 2) begin
            errors++;
            $display("FAIL bp_drain: got %0d responses, required 2", rsps);
        end
        idle();
    endtask

    task automatic test_wrap();
        int n;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, rnd(), rnd());
        req_valid = 4'b1000;
        n = 0;
        @(negedge clk);
        while (req_ready[3] !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready[3] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first: got %b, required 1000", req_ready);
        end
        tick();
        req_valid = 4'b1001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_zero: got %b, required 0001", req_ready);
        end
        tick();
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_three: got %b, required 1000", req_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        set_lane(1, rnd(), rnd());
        req_valid = 4'b0010;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || req_ready !== '0) begin
            errors++;
            $display("FAIL mid_full: got valid %b ready %b, required 1 and 0", rsp_valid,
                     req_ready);
        end
        tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale: cycle %0d got rsp_valid %b, required 0", c, rsp_valid);
            end
            tick();
        end
        req_valid = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr: got %b, required 0001", req_ready);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        int start;
        int cycles;
        start  = rsp_count;
        cycles = 0;
        while (rsp_count - start < 10000 && cycles < 40000) begin
            req_valid = NUM_REQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 7) == 0) set_lane(i, '1, rnd());
                else set_lane(i, rnd(), rnd());
            end
            tick();
            cycles++;
        end
        idle();
        checks++;
        if (rsp_count - start < 10000 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL random_done: got %0d responses %0d pending, required 10000 and 0",
                     rsp_count - start, sb_q.size());
        end
    endtask

    initial begin
        logic [WIDTH:0] big;
        big        = '0;
        big[WIDTH] = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) wait_cnt[i] = 0;
        test_reset();
        test_single(WIDTH'(5), WIDTH'(7), (WIDTH + 1)'(12));
        test_single('1, WIDTH'(1), big);
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
